// File: rtl/stack_renderer_if.sv
// Layer load port between the game FSM (master) and stack_renderer (slave).
// Carries push/clear strobes and the stack occupancy back to the FSM.
interface stack_renderer_if #(
  parameter int MAX_LAYERS = 16
);
  localparam int CW = $clog2(MAX_LAYERS + 1);

  logic          push;
  logic [9:0]    push_x;
  logic [1:0]    push_color;
  logic          clear;
  logic [CW-1:0] count;
  logic          full;

  modport master (
    output push, push_x, push_color, clear,
    input  count, full
  );

  modport slave (
    input  push, push_x, push_color, clear,
    output count, full
  );
endinterface

// File: rtl/stack_renderer.sv
// Stacked-layer renderer: two-stage pixel pipeline from vga x/y to RGB.
// Define STACK_OUTLINE_EN to paint layer edges white.
module stack_renderer #(
  parameter int MAX_LAYERS = 16,
  parameter int LAYER_H    = 20,
  parameter int BLOCK_W    = 150,
  parameter int BASE_Y     = 400
) (
  input  logic       dclk,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       hs_in,
  input  logic       vs_in,
  stack_renderer_if.slave ctl,
  output logic       HS,
  output logic       VS,
  output logic [2:0] RED,
  output logic [2:0] GREEN,
  output logic [1:0] BLUE
);
  localparam int CW = $clog2(MAX_LAYERS + 1);
  localparam int IW = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1;

  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic [9:0]    layer_x_q [MAX_LAYERS];
  logic [9:0]    layer_x_d [MAX_LAYERS];
  logic [1:0]    layer_c_q [MAX_LAYERS];
  logic [1:0]    layer_c_d [MAX_LAYERS];

  logic [MAX_LAYERS-1:0] hit1_q, hit1_d;
  logic                  hs1_q, vs1_q;
  logic                  hs2_q, vs2_q;
  logic [2:0]            red_q, red_d;
  logic [2:0]            green_q, green_d;
  logic [1:0]            blue_q, blue_d;

  always_comb begin
    count_d   = count_q;
    layer_x_d = layer_x_q;
    layer_c_d = layer_c_q;
    if (ctl.clear) begin
      count_d = '0;
    end else if (ctl.push && !full_q) begin
      layer_x_d[count_q[IW-1:0]] = ctl.push_x;
      layer_c_d[count_q[IW-1:0]] = ctl.push_color;
      count_d = count_q + 1'b1;
    end
    full_d = (count_d == CW'(MAX_LAYERS));
  end

  // Signed 12-bit geometry keeps negative band tops and x+BLOCK_W > 1023 exact.
  logic signed [11:0] xs, ys, lx, rx, top, bot;
  logic               act;

`ifdef STACK_OUTLINE_EN
  logic [MAX_LAYERS-1:0] edge1_q, edge1_d;
`endif

  always_comb begin
    xs  = signed'({2'b00, x});
    ys  = signed'({2'b00, y});
    lx  = '0;
    rx  = '0;
    top = '0;
    bot = '0;
    act = 1'b0;
    hit1_d = '0;
`ifdef STACK_OUTLINE_EN
    edge1_d = '0;
`endif
    for (int i = 0; i < MAX_LAYERS; i++) begin
      lx  = signed'({2'b00, layer_x_q[i]});
      rx  = lx + 12'(BLOCK_W);
      top = 12'(BASE_Y - (i + 1) * LAYER_H);
      bot = 12'(BASE_Y - i * LAYER_H);
      act = (CW'(i) < count_q) && (layer_c_q[i] != 2'b00);
      hit1_d[i] = act && (xs > lx) && (xs < rx)
                      && (ys > top) && (ys < bot);
`ifdef STACK_OUTLINE_EN
      edge1_d[i] = act &&
        (((xs == lx || xs == rx) && ys >= top && ys <= bot) ||
         ((ys == top || ys == bot) && xs >= lx && xs <= rx));
`endif
    end
  end

  logic [1:0] sel;

  always_comb begin
    sel     = 2'b00;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    for (int i = MAX_LAYERS - 1; i >= 0; i--) begin
      if (hit1_q[i]) sel = layer_c_q[i];
    end
`ifdef STACK_OUTLINE_EN
    if (|edge1_q) sel = 2'b00;
`endif
    unique case (sel)
      2'b10:   red_d   = 3'd7;
      2'b01:   green_d = 3'd7;
      2'b11:   blue_d  = 2'd3;
      default: ;
    endcase
`ifdef STACK_OUTLINE_EN
    if (|edge1_q) begin
      red_d   = 3'd7;
      green_d = 3'd7;
      blue_d  = 2'd3;
    end
`endif
  end

  always_ff @(posedge dclk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      for (int i = 0; i < MAX_LAYERS; i++) begin
        layer_x_q[i] <= '0;
        layer_c_q[i] <= '0;
      end
      hit1_q  <= '0;
`ifdef STACK_OUTLINE_EN
      edge1_q <= '0;
`endif
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hs2_q   <= 1'b1;
      vs2_q   <= 1'b1;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      count_q   <= count_d;
      full_q    <= full_d;
      layer_x_q <= layer_x_d;
      layer_c_q <= layer_c_d;
      hit1_q    <= hit1_d;
`ifdef STACK_OUTLINE_EN
      edge1_q   <= edge1_d;
`endif
      hs1_q     <= hs_in;
      vs1_q     <= vs_in;
      hs2_q     <= hs1_q;
      vs2_q     <= vs1_q;
      red_q     <= red_d;
      green_q   <= green_d;
      blue_q    <= blue_d;
    end
  end

  assign ctl.count = count_q;
  assign ctl.full  = full_q;
  assign HS    = hs2_q;
  assign VS    = vs2_q;
  assign RED   = red_q;
  assign GREEN = green_q;
  assign BLUE  = blue_q;
endmodule
